// File: rtl/framebuffer_arbiter.sv
// framebuffer_arbiter: owns the single framebuffer RAM port and shares it
// between the display read path (highest priority), the clear/fill engine
// and the host write port. Display reads always win, so writes only land in
// cycles the display leaves free.
module framebuffer_arbiter #(
   parameter int VGA_WIDTH       = 640,
   parameter int VGA_HEIGHT      = 480,
   parameter int VGA_COLOR_DEPTH = 4,
   parameter int PIXEL_WIDTH     = VGA_COLOR_DEPTH * 3,
   parameter int ADDR_WIDTH      = 19
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   disp_req,
   input  logic [ADDR_WIDTH-1:0]  disp_addr,
   output logic                   disp_valid,
   output logic [PIXEL_WIDTH-1:0] disp_data,
   input  logic                   wr_valid,
   output logic                   wr_ready,
   input  logic [ADDR_WIDTH-1:0]  wr_addr,
   input  logic [PIXEL_WIDTH-1:0] wr_data,
   output logic                   wr_oob,
   input  logic                   clear_start,
   input  logic [PIXEL_WIDTH-1:0] clear_color,
   output logic                   clear_busy,
   output logic                   clear_done,
   output logic                   mem_en,
   output logic                   mem_we,
   output logic [ADDR_WIDTH-1:0]  mem_addr,
   output logic [PIXEL_WIDTH-1:0] mem_wdata,
   input  logic [PIXEL_WIDTH-1:0] mem_rdata
);

   localparam int NUM_WORDS = VGA_WIDTH * VGA_HEIGHT;
   localparam int AW1       = ADDR_WIDTH + 1;
   // One extra bit so the range limit is representable even when the buffer
   // fills the whole address space.
   localparam logic [ADDR_WIDTH:0]   NUM_WORDS_W = AW1'(NUM_WORDS);
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX    = ADDR_WIDTH'(NUM_WORDS - 1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   state_t                 state_r;
   state_t                 state_nxt_s;
   logic [ADDR_WIDTH-1:0]  fill_cnt_r;
   logic [ADDR_WIDTH-1:0]  fill_cnt_nxt_s;
   logic [PIXEL_WIDTH-1:0] clear_color_r;
   logic [PIXEL_WIDTH-1:0] clear_color_nxt_s;
   logic                   disp_valid_r;
   logic                   wr_oob_r;
   logic                   clear_busy_r;
   logic                   clear_done_r;
   logic                   clear_done_nxt_s;
   logic                   wr_ready_s;
   logic                   wr_fire_s;
   logic                   wr_in_range_s;
   logic                   fill_own_s;

   // A host write may only proceed when the port is free and no fill is
   // starting or running; clear_start stalls a simultaneous host write.
   assign wr_ready_s    = wr_valid & ~disp_req & (state_r == ST_IDLE) & ~clear_start;
   assign wr_fire_s     = wr_valid & wr_ready_s;
   assign wr_in_range_s = ({1'b0, wr_addr} < NUM_WORDS_W);
   assign fill_own_s    = (state_r == ST_CLEAR) & ~disp_req;
   assign wr_ready      = wr_ready_s;

   // Port grant: display read, then fill write, then in-range host write.
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = {ADDR_WIDTH{1'b0}};
      mem_wdata = {PIXEL_WIDTH{1'b0}};
      if (disp_req) begin
         mem_en   = 1'b1;
         mem_addr = disp_addr;
      end else if (state_r == ST_CLEAR) begin
         mem_en    = 1'b1;
         mem_we    = 1'b1;
         mem_addr  = fill_cnt_r;
         mem_wdata = clear_color_r;
      end else if (wr_fire_s && wr_in_range_s) begin
         mem_en    = 1'b1;
         mem_we    = 1'b1;
         mem_addr  = wr_addr;
         mem_wdata = wr_data;
      end else begin
         mem_en = 1'b0;
      end
   end

   // Fill FSM next state, fill counter and colour latch.
   always_comb begin
      state_nxt_s       = state_r;
      fill_cnt_nxt_s    = fill_cnt_r;
      clear_color_nxt_s = clear_color_r;
      clear_done_nxt_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (clear_start) begin
               state_nxt_s       = ST_CLEAR;
               fill_cnt_nxt_s    = {ADDR_WIDTH{1'b0}};
               clear_color_nxt_s = clear_color;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_CLEAR: begin
            if (fill_own_s) begin
               if (fill_cnt_r == LAST_IDX) begin
                  state_nxt_s      = ST_IDLE;
                  clear_done_nxt_s = 1'b1;
               end else begin
                  fill_cnt_nxt_s = fill_cnt_r + ADDR_WIDTH'(1);
               end
            end else begin
               state_nxt_s = ST_CLEAR;
            end
         end
         default: begin
            state_nxt_s    = ST_IDLE;
            fill_cnt_nxt_s = {ADDR_WIDTH{1'b0}};
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Fill counter and latched fill colour.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fill_cnt_r    <= {ADDR_WIDTH{1'b0}};
         clear_color_r <= {PIXEL_WIDTH{1'b0}};
      end else begin
         fill_cnt_r    <= fill_cnt_nxt_s;
         clear_color_r <= clear_color_nxt_s;
      end
   end

   // Registered status outputs: read-data valid, OOB pulse, busy and done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp_valid_r <= 1'b0;
         wr_oob_r     <= 1'b0;
         clear_busy_r <= 1'b0;
         clear_done_r <= 1'b0;
      end else begin
         disp_valid_r <= disp_req;
         wr_oob_r     <= wr_fire_s & ~wr_in_range_s;
         clear_busy_r <= (state_nxt_s == ST_CLEAR);
         clear_done_r <= clear_done_nxt_s;
      end
   end

   assign disp_valid = disp_valid_r;
   assign disp_data  = disp_valid_r ? mem_rdata : {PIXEL_WIDTH{1'b0}};
   assign wr_oob     = wr_oob_r;
   assign clear_busy = clear_busy_r;
   assign clear_done = clear_done_r;

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Testbench for framebuffer_arbiter on a 8x4 (32-word) buffer with a
// 1-cycle-read RAM model and a behavioural reference model.
module tb_framebuffer_arbiter;

   localparam int W  = 8;
   localparam int H  = 4;
   localparam int AW = 6;
   localparam int PW = 12;
   localparam int NW = W * H;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          disp_req;
   logic [AW-1:0] disp_addr;
   logic          disp_valid;
   logic [PW-1:0] disp_data;
   logic          wr_valid;
   logic          wr_ready;
   logic [AW-1:0] wr_addr;
   logic [PW-1:0] wr_data;
   logic          wr_oob;
   logic          clear_start;
   logic [PW-1:0] clear_color;
   logic          clear_busy;
   logic          clear_done;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [PW-1:0] mem_wdata;
   logic [PW-1:0] mem_rdata;

   always #5 clk = ~clk;

   framebuffer_arbiter #(
      .VGA_WIDTH(W), .VGA_HEIGHT(H), .VGA_COLOR_DEPTH(4), .PIXEL_WIDTH(PW), .ADDR_WIDTH(AW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .disp_req(disp_req), .disp_addr(disp_addr), .disp_valid(disp_valid), .disp_data(disp_data),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_oob(wr_oob),
      .clear_start(clear_start), .clear_color(clear_color), .clear_busy(clear_busy), .clear_done(clear_done),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // RAM model: synchronous read, one write port, counts writes.
   logic [PW-1:0] ram [0:63];
   logic          ram_clr;
   int            ram_wr_cnt;
   always @(posedge clk) begin
      if (ram_clr) begin
         for (int i = 0; i < 64; i++) ram[i] <= '0;
         ram_wr_cnt <= 0;
         mem_rdata  <= '0;
      end else if (mem_en) begin
         if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            ram_wr_cnt    <= ram_wr_cnt + 1;
         end else begin
            mem_rdata <= ram[mem_addr];
         end
      end
   end

   // Reference model state
   logic [PW-1:0] m_mem [0:63];
   bit            m_clearing;
   int            m_fill;
   int            m_color;
   bit            m_dv;
   logic [PW-1:0] m_rd;
   bit            m_oob;
   bit            m_done;

   // Observed outputs of the last step
   logic          obs_ready, obs_en, obs_we, obs_dv, obs_oob, obs_busy, obs_done;
   logic [AW-1:0] obs_addr;
   logic [PW-1:0] obs_wdata, obs_data;

   int n_vec;
   int n_err;

   typedef struct {
      bit dr; int da; bit wv; int wa; int wd;
      bit ready; bit en; bit we; int addr; int wdata;
      bit dv; int ddata; bit oob;
   } vec_t;
   vec_t tbl [8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_clearing = 1'b0;
      m_fill     = 0;
      m_color    = 0;
      m_dv       = 1'b0;
      m_rd       = '0;
      m_oob      = 1'b0;
      m_done     = 1'b0;
   endtask

   // One clock cycle: drive at negedge, check, advance model at posedge.
   task automatic step(input bit dr, input int da, input bit wv, input int wa,
                       input int wd, input bit cs, input int cc);
      bit e_ready, e_en, e_we;
      int e_addr, e_wdata;
      disp_req    = dr;
      disp_addr   = AW'(da);
      wr_valid    = wv;
      wr_addr     = AW'(wa);
      wr_data     = PW'(wd);
      clear_start = cs;
      clear_color = PW'(cc);
      #1;
      e_ready = wv && !dr && !m_clearing && !cs;
      e_en = 1'b0; e_we = 1'b0; e_addr = 0; e_wdata = 0;
      if (dr) begin
         e_en = 1'b1; e_addr = da;
      end else if (m_clearing) begin
         e_en = 1'b1; e_we = 1'b1; e_addr = m_fill; e_wdata = m_color;
      end else if (e_ready && wa < NW) begin
         e_en = 1'b1; e_we = 1'b1; e_addr = wa; e_wdata = wd & 32'hFFF;
      end
      obs_ready = wr_ready; obs_en = mem_en; obs_we = mem_we; obs_addr = mem_addr;
      obs_wdata = mem_wdata; obs_dv = disp_valid; obs_data = disp_data;
      obs_oob = wr_oob; obs_busy = clear_busy; obs_done = clear_done;
      chk("wr_ready", wr_ready, e_ready);
      chk("mem_en", mem_en, e_en);
      if (e_en) begin
         chk("mem_we", mem_we, e_we);
         chk("mem_addr", mem_addr, e_addr);
         if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
      end
      chk("disp_valid", disp_valid, m_dv);
      chk("disp_data", disp_data, m_dv ? m_rd : '0);
      chk("wr_oob", wr_oob, m_oob);
      chk("clear_busy", clear_busy, m_clearing);
      chk("clear_done", clear_done, m_done);
      @(posedge clk);
      m_dv = dr;
      if (dr) m_rd = m_mem[da];
      m_oob = e_ready && (wa >= NW);
      if (e_we) m_mem[e_addr] = PW'(e_wdata);
      m_done = 1'b0;
      if (m_clearing) begin
         if (!dr) begin
            if (m_fill == NW - 1) begin
               m_clearing = 1'b0;
               m_done     = 1'b1;
            end else begin
               m_fill++;
            end
         end
      end else if (cs) begin
         m_clearing = 1'b1;
         m_fill     = 0;
         m_color    = cc & 32'hFFF;
      end
      @(negedge clk);
   endtask

   task automatic idle_step();
      step(1'b0, 0, 1'b0, 0, 0, 1'b0, 0);
   endtask

   // Asynchronous reset in the middle of a low clock phase.
   task automatic apply_reset(input int hold);
      disp_req = 1'b0; wr_valid = 1'b0; clear_start = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_busy", clear_busy, 1'b0);
      chk("rst_done", clear_done, 1'b0);
      chk("rst_valid", disp_valid, 1'b0);
      chk("rst_oob", wr_oob, 1'b0);
      model_reset();
      repeat (hold) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Read every word back and require the given value.
   task automatic readback(input string nm, input int exp_val);
      for (int a = 0; a <= NW; a++) begin
         step(a < NW, (a < NW) ? a : 0, 1'b0, 0, 0, 1'b0, 0);
         if (a > 0) chk(nm, obs_data, exp_val);
      end
   endtask

   // Run a fill until clear_done; toggle selects disp_req on even cycles.
   task automatic run_fill(input bit toggle, output int busy_cnt, output int wr_cnt,
                           output int done_cnt);
      busy_cnt = 0; wr_cnt = 0; done_cnt = 0;
      for (int i = 0; i < 200; i++) begin
         step(toggle && (i % 2 == 0), $urandom_range(0, NW - 1), 1'b0, 0, 0,
              toggle && (i == 20), 12'h111);
         if (obs_busy) busy_cnt++;
         if (obs_en && obs_we) wr_cnt++;
         if (obs_done) begin
            done_cnt++;
            break;
         end
      end
      for (int i = 0; i < 5; i++) begin
         idle_step();
         if (obs_done) done_cnt++;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int base, busy_cnt, wr_cnt, done_cnt;
      n_vec = 0; n_err = 0;
      rst_n = 1'b0; ram_clr = 1'b1;
      disp_req = 1'b0; disp_addr = '0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
      clear_start = 1'b0; clear_color = '0;
      for (int i = 0; i < 64; i++) m_mem[i] = '0;
      model_reset();
      repeat (3) @(negedge clk);
      ram_clr = 1'b0;
      rst_n   = 1'b1;

      // Reset state with idle inputs
      repeat (4) idle_step();

      // Table-driven basic grant / data vectors
      tbl[0] = '{0, 0, 0, 0, 0,       0, 0, 0, 0, 0,       0, 0,       0};
      tbl[1] = '{0, 0, 1, 5, 'hABC,   1, 1, 1, 5, 'hABC,   0, 0,       0};
      tbl[2] = '{1, 5, 0, 0, 0,       0, 1, 0, 5, 0,       0, 0,       0};
      tbl[3] = '{1, 5, 1, 7, 'h123,   0, 1, 0, 5, 0,       1, 'hABC,   0};
      tbl[4] = '{0, 0, 1, 7, 'h123,   1, 1, 1, 7, 'h123,   1, 'hABC,   0};
      tbl[5] = '{0, 0, 1, 40, 'h555,  1, 0, 0, 0, 0,       0, 0,       0};
      tbl[6] = '{1, 7, 0, 0, 0,       0, 1, 0, 7, 0,       0, 0,       1};
      tbl[7] = '{0, 0, 0, 0, 0,       0, 0, 0, 0, 0,       1, 'h123,   0};
      for (int i = 0; i < 8; i++) begin
         step(tbl[i].dr, tbl[i].da, tbl[i].wv, tbl[i].wa, tbl[i].wd, 1'b0, 0);
         chk("tbl_ready", obs_ready, tbl[i].ready);
         chk("tbl_en", obs_en, tbl[i].en);
         if (tbl[i].en) begin
            chk("tbl_we", obs_we, tbl[i].we);
            chk("tbl_addr", obs_addr, tbl[i].addr);
            if (tbl[i].we) chk("tbl_wdata", obs_wdata, tbl[i].wdata);
         end
         chk("tbl_dv", obs_dv, tbl[i].dv);
         chk("tbl_ddata", obs_data, tbl[i].ddata);
         chk("tbl_oob", obs_oob, tbl[i].oob);
      end

      // Host write stalled by 3 display cycles, then exactly one RAM write
      base = ram_wr_cnt;
      for (int i = 0; i < 3; i++) begin
         step(1'b1, i, 1'b1, 12, 'h3C3, 1'b0, 0);
         chk("stall_ready", obs_ready, 1'b0);
      end
      step(1'b0, 0, 1'b1, 12, 'h3C3, 1'b0, 0);
      chk("stall_accept", obs_ready, 1'b1);
      idle_step();
      chk("stall_one_write", ram_wr_cnt - base, 1);

      // Fill with no display traffic
      step(1'b0, 0, 1'b0, 0, 0, 1'b1, 'h0F0);
      run_fill(1'b0, busy_cnt, wr_cnt, done_cnt);
      chk("clr_busy_cycles", busy_cnt, 32);
      chk("clr_writes", wr_cnt, 32);
      chk("clr_done_once", done_cnt, 1);
      readback("clr_readback", 'h0F0);

      // Host write sets one word so the next fill visibly overwrites it
      step(1'b0, 0, 1'b1, 3, 'h777, 1'b0, 0);

      // Fill with display toggling; re-start with 0x111 mid-fill is ignored
      step(1'b0, 0, 1'b0, 0, 0, 1'b1, 'h0F0);
      run_fill(1'b1, busy_cnt, wr_cnt, done_cnt);
      chk("clr2_busy_cycles", busy_cnt, 64);
      chk("clr2_writes", wr_cnt, 32);
      chk("clr2_done_once", done_cnt, 1);
      readback("clr2_readback", 'h0F0);

      // Reset while fill_cnt = 10 aborts the fill without clear_done
      step(1'b0, 0, 1'b0, 0, 0, 1'b1, 'h5A5);
      repeat (10) idle_step();
      chk("abort_last_addr", obs_addr, 9);
      apply_reset(2);
      done_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         idle_step();
         if (obs_done) done_cnt++;
      end
      chk("abort_no_done", done_cnt, 0);

      // Randomized traffic against the reference model
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 99) < 40, $urandom_range(0, NW - 1),
              $urandom_range(0, 1) == 1, $urandom_range(0, 39),
              int'($urandom_range(0, 4095)), $urandom_range(0, 99) < 2,
              int'($urandom_range(0, 4095)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
